// File: rtl/ct_spsram_shadow_param.sv
// Parametrised single-port SRAM with group write enables, a post-reset clear sweep and a registered read port.
// Optional per-bit taint shadow array enabled by defining CT_SPSRAM_TAINT_EN.
module ct_spsram_shadow_param #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WE_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [WE_WIDTH-1:0]   WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  INIT_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned G     = DATA_WIDTH / WE_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   q_q;
    logic                    init_done_q;
    logic                    init_wr_c;
    logic                    acc_wr_c;
    logic                    acc_rd_c;
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

    // State register
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sweep leaves INIT on the edge that clears the last entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (cnt_q == CNT_LAST) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // Per-state control decode
    always_comb begin
        init_wr_c = 1'b0;
        acc_wr_c  = 1'b0;
        acc_rd_c  = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_INIT: begin
                init_wr_c = 1'b1;
                cnt_d     = CNT_W'(cnt_q + 1'b1);
            end
            ST_READY: begin
                acc_wr_c = !CEN && !GWEN;
                acc_rd_c = !CEN && GWEN;
            end
            default: ;
        endcase
    end

    // Sweep counter, read register and ready flag
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            cnt_q       <= '0;
            q_q         <= '0;
            init_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == ST_READY);
            if (acc_rd_c) begin
                q_q <= data_mem[A];
            end
        end
    end

    // Data array: sweep clear or group-masked write
    always_ff @(posedge CLK) begin
        if (cpurst_b) begin
            if (init_wr_c) begin
                data_mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
            end else if (acc_wr_c) begin
                for (int unsigned g = 0; g < WE_WIDTH; g++) begin
                    if (!WEN[g]) begin
                        data_mem[A][g*G +: G] <= D[g*G +: G];
                    end
                end
            end
        end
    end

    assign Q         = q_q;
    assign INIT_DONE = init_done_q;

`ifdef CT_SPSRAM_TAINT_EN
    logic [DATA_WIDTH-1:0] shadow_mem [DEPTH];
    logic [DATA_WIDTH-1:0] qt_q;
    logic                  ctl_t_c;
    logic                  idle_t_c;

    assign ctl_t_c  = (|A_t0) | CEN_t0 | GWEN_t0;
    assign idle_t_c = (state_q == ST_READY) && CEN && CEN_t0;

    // Shadow array: a tainted enable or control taints the whole group
    always_ff @(posedge CLK) begin
        if (cpurst_b) begin
            if (init_wr_c) begin
                shadow_mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
            end else if (acc_wr_c) begin
                for (int unsigned g = 0; g < WE_WIDTH; g++) begin
                    if (!WEN[g] || WEN_t0[g] || ctl_t_c) begin
                        shadow_mem[A][g*G +: G] <= D_t0[g*G +: G] | {G{ctl_t_c | WEN_t0[g]}};
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            qt_q <= '0;
        end else if (acc_rd_c) begin
            qt_q <= shadow_mem[A] | {DATA_WIDTH{ctl_t_c}};
        end else if (idle_t_c) begin
            qt_q <= '1;
        end
    end

    assign Q_t0 = qt_q;
`else
    logic unused_taint;
    assign unused_taint = ^{A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0};
    assign Q_t0         = '0;
`endif

endmodule

// File: tb/tb_ct_spsram_shadow_param.sv
// Scoreboard bench for ct_spsram_shadow_param: reads push expected Q/Q_t0, a monitor checks after the edge.
module tb_ct_spsram_shadow_param;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 16;
`ifdef CT_SPSRAM_TAINT_EN
    localparam bit TAINT = 1'b1;
`else
    localparam bit TAINT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic [AW-1:0] a, a_t0;
    logic          cen, cen_t0, gwen, gwen_t0;
    logic [WW-1:0] wen, wen_t0;
    logic [DW-1:0] d, d_t0;
    logic [DW-1:0] q, q_t0;
    logic          init_done;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] qt;
        string         name;
    } exp_t;

    exp_t sb[$];
    logic exp_req;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ct_spsram_shadow_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) dut (
        .CLK(clk), .cpurst_b(cpurst_b),
        .A(a), .A_t0(a_t0), .CEN(cen), .CEN_t0(cen_t0), .GWEN(gwen), .GWEN_t0(gwen_t0),
        .WEN(wen), .WEN_t0(wen_t0), .D(d), .D_t0(d_t0),
        .Q(q), .Q_t0(q_t0), .INIT_DONE(init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: an output event requested before this edge is checked just after it
    always @(posedge clk) begin
        automatic logic v = exp_req;
        #1;
        if (v) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                automatic exp_t e = sb.pop_front();
                chk({e.name, "_q"}, 32'(q), 32'(e.q));
                chk({e.name, "_qt"}, 32'(q_t0), 32'(e.qt));
            end
        end
    end

    task automatic drv_idle();
        cen = 1'b1; cen_t0 = 1'b0; gwen = 1'b1; gwen_t0 = 1'b0;
        a = '0; a_t0 = '0; wen = '1; wen_t0 = '0; d = '0; d_t0 = '0;
        exp_req = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dv, input logic [WW-1:0] wn,
                      input logic [DW-1:0] dt, input logic [WW-1:0] wt);
        @(negedge clk);
        drv_idle();
        cen = 1'b0; gwen = 1'b0; a = ad; d = dv; wen = wn; d_t0 = dt; wen_t0 = wt;
    endtask

    task automatic rd(input logic [AW-1:0] ad, input logic [AW-1:0] at,
                      input logic [DW-1:0] eq, input logic [DW-1:0] eqt, input string name);
        exp_t e;
        @(negedge clk);
        drv_idle();
        cen = 1'b0; gwen = 1'b1; a = ad; a_t0 = at;
        e.q = eq; e.qt = TAINT ? eqt : '0; e.name = name;
        sb.push_back(e);
        exp_req = 1'b1;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        drv_idle();
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        drv_idle();
        cpurst_b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Release reset and count edges until the sweep should complete
    task automatic sweep(input string name);
        cpurst_b = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            if (k == 60) chk({name, "_init_q"}, 32'(q), 32'd0);
            if (k == 127) chk({name, "_done_127"}, 32'(init_done), 32'd0);
            if (k == 128) chk({name, "_done_128"}, 32'(init_done), 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        cpurst_b = 1'b0;
        drv_idle();

        // 1: reset, sweep, cleared entries
        hold_reset(2);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qt", 32'(q_t0), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        sweep("sweep1");
        rd(7'd0,   7'd0, 16'h0000, 16'h0000, "clr0");
        rd(7'd64,  7'd0, 16'h0000, 16'h0000, "clr64");
        rd(7'd127, 7'd0, 16'h0000, 16'h0000, "clr127");

        // 2: full write then read
        wr(7'd5, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000);
        rd(7'd5, 7'd0, 16'hA5C3, 16'h0000, "wr5");

        // 3: partial group write
        wr(7'd9, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        wr(7'd9, 16'h0000, 16'hFF00, 16'h0000, 16'h0000);
        rd(7'd9, 7'd0, 16'hFF00, 16'h0000, "part9");

        // 4: taint build, address taint, idle chip-enable taint
        wr(7'd3, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h8000);
        rd(7'd3, 7'd0, 16'h0001, 16'h8001, "taint3");
        rd(7'd3, 7'd1, 16'h0001, 16'hFFFF, "ataint3");
        rd(7'd5, 7'd0, 16'hA5C3, 16'h0000, "clean5");
        @(negedge clk);
        drv_idle();
        cen_t0 = 1'b1;
        e.q = 16'hA5C3; e.qt = TAINT ? 16'hFFFF : 16'h0000; e.name = "cen_t0";
        sb.push_back(e);
        exp_req = 1'b1;
        idle_cyc();

        // 5: reset mid-sweep, accesses during INIT ignored
        hold_reset(2);
        cpurst_b = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            drv_idle();
            if (k == 10) begin
                cen = 1'b0; gwen = 1'b0; a = 7'd7; d = 16'hBEEF; wen = '0;
            end
        end
        chk("mid_done", 32'(init_done), 32'd0);
        hold_reset(2);
        cpurst_b = 1'b1;
        @(negedge clk);
        cen = 1'b0; gwen = 1'b0; a = 7'd100; d = 16'h1111; wen = '0;
        for (int k = 2; k <= 128; k++) begin
            @(negedge clk);
            drv_idle();
            if (k == 127) chk("resweep_done_127", 32'(init_done), 32'd0);
            if (k == 128) chk("resweep_done_128", 32'(init_done), 32'd1);
        end
        rd(7'd7,   7'd0, 16'h0000, 16'h0000, "init7");
        rd(7'd100, 7'd0, 16'h0000, 16'h0000, "init100");
        rd(7'd5,   7'd0, 16'h0000, 16'h0000, "reclr5");
        rd(7'd3,   7'd0, 16'h0000, 16'h0000, "reclr3");
        idle_cyc();
        idle_cyc();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
